// File: rtl/sega_pad_pkg.sv
// Shared definitions for the Sega DB9 pad responder.
//  - Bit positions of the 12-bit button word (MXYZ SACB RLDU, positive logic).
//  - Bit positions of the 6-bit pad word (active-low pin levels).
//  - Phase code emitted on phase_o.
//  - pad_encode(): maps a phase and the button word to pad pin levels.
package sega_pad_pkg;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_B = 4;
  localparam int BTN_C = 5;
  localparam int BTN_A = 6;
  localparam int BTN_S = 7;
  localparam int BTN_Z = 8;
  localparam int BTN_Y = 9;
  localparam int BTN_X = 10;
  localparam int BTN_M = 11;

  localparam int PAD_R  = 0;
  localparam int PAD_L  = 1;
  localparam int PAD_D  = 2;
  localparam int PAD_U  = 3;
  localparam int PAD_P6 = 4;
  localparam int PAD_P9 = 5;

  typedef enum logic [2:0] {
    PH_HI = 3'd0,
    PH_LO = 3'd1,
    PH_ID = 3'd2,
    PH_XH = 3'd3,
    PH_L4 = 3'd4
  } pad_phase_t;

  // Builds an "asserted" vector (1 = line pulled low) and inverts it to pin levels.
  // Lines forced low in a phase are asserted; lines forced high are left released.
  function automatic logic [5:0] pad_encode(input pad_phase_t ph, input logic [11:0] b);
    logic [5:0] a;
    a = '0;
    case (ph)
      PH_LO: begin
        a[PAD_P9] = b[BTN_S];  a[PAD_P6] = b[BTN_A];
        a[PAD_U]  = b[BTN_U];  a[PAD_D]  = b[BTN_D];
        a[PAD_L]  = 1'b1;      a[PAD_R]  = 1'b1;
      end
      PH_ID: begin
        a[PAD_P9] = b[BTN_S];  a[PAD_P6] = b[BTN_A];
        a[PAD_U]  = 1'b1;      a[PAD_D]  = 1'b1;
        a[PAD_L]  = 1'b1;      a[PAD_R]  = 1'b1;
      end
      PH_XH: begin
        a[PAD_P9] = b[BTN_C];  a[PAD_P6] = b[BTN_B];
        a[PAD_U]  = b[BTN_Z];  a[PAD_D]  = b[BTN_Y];
        a[PAD_L]  = b[BTN_X];  a[PAD_R]  = b[BTN_M];
      end
      PH_L4: begin
        a[PAD_P9] = b[BTN_S];  a[PAD_P6] = b[BTN_A];
      end
      default: begin
        a[PAD_P9] = b[BTN_C];  a[PAD_P6] = b[BTN_B];
        a[PAD_U]  = b[BTN_U];  a[PAD_D]  = b[BTN_D];
        a[PAD_L]  = b[BTN_L];  a[PAD_R]  = b[BTN_R];
      end
    endcase
    return ~a;
  endfunction

endpackage

// File: rtl/sega_pad_responder_sel_sync.sv
// Select-line synchroniser.
//  - SYNC_STAGES flops on sel_i (SYNC_STAGES must be >= 2), all reset to 1 because
//    the select line idles high.
//  - rise_o/fall_o are registered strobes, high for exactly the cycle in which
//    sel_o shows the new level.
// Ports: clk_sys, reset (async, active high), sel_i (async pin),
//        sel_o (synchronised level), rise_o, fall_o (1-cycle strobes).
module sega_pad_sel_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic sel_i,
  output logic sel_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Strobes look one stage ahead so they line up with the level change on sel_o.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sel_i};
    rise_d = ~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES-2];
    fall_d =  sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sel_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sega_pad_responder.sv
// Device end of the DB9 Mega Drive pad protocol (3/6-button Sega pad emulation).
//  - Synchronises the host select line and drives the six active-low pad lines
//    {p9,p6,U,D,L,R}, multiplexed per select phase.
//  - Build option SEGA_PAD_6BTN_EN: when defined, full 6-button behaviour (low-phase
//    counter, idle timeout, ID/XH/L4 phases). When undefined, a plain 3-button pad.
// Ports: clk_sys, reset (async, active high), sel_i (host select, async),
//        btn_i[11:0] (MXYZ SACB RLDU, positive logic),
//        pad_o[5:0] ([5]=p9 [4]=p6 [3]=U [2]=D [1]=L [0]=R, pin levels),
//        phase_o[2:0] (current phase code).
module sega_pad_responder
  import sega_pad_pkg::*;
#(
  parameter int TIMEOUT_CYC = 72000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        sel_i,
  input  logic [11:0] btn_i,
  output logic [5:0]  pad_o,
  output logic [2:0]  phase_o
);

  logic sel_s, sel_rise, sel_fall;

  sega_pad_sel_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sel_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .sel_i   (sel_i),
    .sel_o   (sel_s),
    .rise_o  (sel_rise),
    .fall_o  (sel_fall)
  );

  pad_phase_t  phase_q, phase_d;
  logic [5:0]  pad_q, pad_d;
  logic [11:0] btn_eff;
  logic        unused_sink;

`ifdef SEGA_PAD_6BTN_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]       lcnt_q, lcnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_exp;

  assign btn_eff     = btn_i;
  assign unused_sink = sel_rise;

  // Phase is decoded from the next lcnt value so the first low phase after an edge
  // already uses the updated count; pad_o then lags the synchronised edge by one cycle.
  always_comb begin
    tmo_exp = (tmo_q == TMO_W'(TIMEOUT_CYC));
    lcnt_d  = lcnt_q;
    tmo_d   = tmo_q;
    if (sel_fall) begin
      tmo_d = '0;
      // An edge coinciding with the timeout restarts the count instead of adding to it.
      if (tmo_exp)               lcnt_d = 3'd1;
      else if (lcnt_q != 3'd4)   lcnt_d = lcnt_q + 3'd1;
    end else begin
      if (!tmo_exp)              tmo_d  = tmo_q + TMO_W'(1);
      if (tmo_exp)               lcnt_d = 3'd0;
    end

    phase_d = PH_HI;
    if (sel_s) begin
      if (lcnt_d == 3'd3) phase_d = PH_XH;
    end else begin
      case (lcnt_d)
        3'd3:    phase_d = PH_ID;
        3'd4:    phase_d = PH_L4;
        default: phase_d = PH_LO;   // lcnt 0 also reads as a normal low phase
      endcase
    end
    pad_d = pad_encode(phase_d, btn_eff);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lcnt_q <= 3'd0;
      tmo_q  <= '0;
    end else begin
      lcnt_q <= lcnt_d;
      tmo_q  <= tmo_d;
    end
  end
`else
  // Extra buttons are dropped so they can never reach the pins.
  assign btn_eff     = {4'b0000, btn_i[7:0]};
  assign unused_sink = ^{sel_rise, sel_fall, btn_i[11:8]};

  always_comb begin
    phase_d = sel_s ? PH_HI : PH_LO;
    pad_d   = pad_encode(phase_d, btn_eff);
  end
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pad_q   <= 6'h3F;
      phase_q <= PH_HI;
    end else begin
      pad_q   <= pad_d;
      phase_q <= phase_d;
    end
  end

  assign pad_o   = pad_q;
  assign phase_o = phase_q;

endmodule

// File: tb/tb_sega_pad_responder.sv
// Bench for sega_pad_responder: directed protocol sequences plus randomised select and
// button activity, each cycle compared against an edge-count reference model.
module tb_sega_pad_responder;

  localparam int T = 60;
  localparam int S = 2;
`ifdef SEGA_PAD_6BTN_EN
  localparam bit SIX = 1'b1;
`else
  localparam bit SIX = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        sel_i;
  logic [11:0] btn_i;
  logic [5:0]  pad_o;
  logic [2:0]  phase_o;

  sega_pad_responder #(.TIMEOUT_CYC(T), .SYNC_STAGES(S)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .sel_i   (sel_i),
    .btn_i   (btn_i),
    .pad_o   (pad_o),
    .phase_o (phase_o)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since release, edge of last select fall, low count.
  logic       hist[$];
  int         edge_n, last_fall, cnt;
  logic       s_prev;
  logic [5:0] exp_pad;
  logic [2:0] exp_ph;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_pad(input int ph, input logic [11:0] b);
    case (ph)
      1:       return {~b[7], ~b[6], ~b[0], ~b[1], 2'b00};
      2:       return {~b[7], ~b[6], 4'b0000};
      3:       return {~b[5], ~b[4], ~b[8], ~b[9], ~b[10], ~b[11]};
      4:       return {~b[7], ~b[6], 4'b1111};
      default: return {~b[5], ~b[4], ~b[0], ~b[1], ~b[2], ~b[3]};
    endcase
  endfunction

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < S; i++) hist.push_back(1'b1);
    edge_n = 0; last_fall = 0; cnt = 0; s_prev = 1'b1;
    exp_pad = 6'h3F; exp_ph = 3'd0;
  endtask

  task automatic model_edge();
    logic s, fall, tout;
    int   ph;
    if (reset) begin
      model_reset();
      return;
    end
    edge_n++;
    s = hist[hist.size() - S];     // pin level seen S edges ago
    hist.push_back(sel_i);
    void'(hist.pop_front());
    fall   = s_prev & ~s;
    s_prev = s;
    tout   = (edge_n - 1 - last_fall) >= T;
    if (fall) begin
      cnt       = tout ? 1 : (cnt < 4 ? cnt + 1 : 4);
      last_fall = edge_n;
    end else if (tout) begin
      cnt = 0;
    end
    if (!SIX)    ph = s ? 0 : 1;
    else if (s)  ph = (cnt == 3) ? 3 : 0;
    else         ph = (cnt == 4) ? 4 : (cnt == 3) ? 2 : 1;
    exp_ph  = 3'(ph);
    exp_pad = model_pad(ph, btn_i);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    chk("pad_cyc", {2'b00, pad_o}, {2'b00, exp_pad});
    chk("ph_cyc", {5'b0, phase_o}, {5'b0, exp_ph});
  endtask

  // Low phase of 'gap' cycles total period; returns phase_o seen S+1 cycles after the fall.
  task automatic pulse_low(input int gap, output logic [2:0] ph);
    sel_i = 1'b0;
    repeat (S + 1) tick();
    ph = phase_o;
    repeat (gap / 2 - (S + 1)) tick();
    sel_i = 1'b1;
    repeat (gap - gap / 2) tick();
  endtask

  logic [5:0] lo_exp  [4];
  logic [2:0] lo_ph   [4];
  logic [5:0] hi_exp  [4];
  logic [2:0] hi_ph   [4];
  logic [2:0] col_ph  [6];
  logic [2:0] got_ph;

  initial begin
    model_reset();
    reset = 1'b1; sel_i = 1'b1; btn_i = 12'hFFF;

    // 1: reset holds all lines released
    repeat (3) tick();
    chk("rst_pad", {2'b00, pad_o}, 8'h3F);
    chk("rst_ph", {5'b0, phase_o}, 8'h00);
    reset = 1'b0; btn_i = 12'h000;
    repeat (4) tick();
    chk("rel_pad", {2'b00, pad_o}, 8'h3F);

    // 2: 3-button read with U,C,S pressed
    btn_i = 12'h0A1;
    tick();
    chk("btn_lat", {2'b00, pad_o}, 8'b0001_0111);
    sel_i = 1'b0;
    repeat (S + 1) tick();
    chk("t2_lo", {2'b00, pad_o}, 8'b0001_0100);
    chk("t2_lo_ph", {5'b0, phase_o}, 8'h01);
    sel_i = 1'b1;
    repeat (S + 1) tick();
    chk("t2_hi", {2'b00, pad_o}, 8'b0001_0111);

    // reset mid-sequence, then 3: 6-button sequence with M,Z pressed
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0; btn_i = 12'h900;
    repeat (5) tick();
    if (SIX) begin
      lo_exp = '{6'h3C, 6'h3C, 6'h30, 6'h3F}; lo_ph = '{3'd1, 3'd1, 3'd2, 3'd4};
      hi_exp = '{6'h3F, 6'h3F, 6'h36, 6'h3F}; hi_ph = '{3'd0, 3'd0, 3'd3, 3'd0};
    end else begin
      lo_exp = '{6'h3C, 6'h3C, 6'h3C, 6'h3C}; lo_ph = '{3'd1, 3'd1, 3'd1, 3'd1};
      hi_exp = '{6'h3F, 6'h3F, 6'h3F, 6'h3F}; hi_ph = '{3'd0, 3'd0, 3'd0, 3'd0};
    end
    for (int i = 0; i < 4; i++) begin
      sel_i = 1'b0;
      repeat (20) tick();
      chk($sformatf("t3_lo%0d", i + 1), {2'b00, pad_o}, {2'b00, lo_exp[i]});
      chk($sformatf("t3_lo%0d_ph", i + 1), {5'b0, phase_o}, {5'b0, lo_ph[i]});
      sel_i = 1'b1;
      repeat (20) tick();
      chk($sformatf("t3_hi%0d", i + 1), {2'b00, pad_o}, {2'b00, hi_exp[i]});
      chk($sformatf("t3_hi%0d_ph", i + 1), {5'b0, phase_o}, {5'b0, hi_ph[i]});
    end

    // 4: idle timeout returns the next low phase to LO
    repeat (T + 5) tick();
    sel_i = 1'b0;
    repeat (S + 1) tick();
    chk("t4_ph", {5'b0, phase_o}, 8'h01);
    chk("t4_pad", {2'b00, pad_o}, 8'h3C);
    sel_i = 1'b1;
    repeat (T + 5) tick();

    // 5: gaps of T keep counting; a fall landing on the timeout restarts at 1
    if (SIX) col_ph = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd2};
    else     col_ph = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    pulse_low(T, got_ph);      chk("t5_l1", {5'b0, got_ph}, {5'b0, col_ph[0]});
    pulse_low(T, got_ph);      chk("t5_l2", {5'b0, got_ph}, {5'b0, col_ph[1]});
    pulse_low(T + 1, got_ph);  chk("t5_l3", {5'b0, got_ph}, {5'b0, col_ph[2]});
    pulse_low(40, got_ph);     chk("t5_col", {5'b0, got_ph}, {5'b0, col_ph[3]});
    pulse_low(40, got_ph);     chk("t5_l5", {5'b0, got_ph}, {5'b0, col_ph[4]});
    pulse_low(40, got_ph);     chk("t5_l6", {5'b0, got_ph}, {5'b0, col_ph[5]});

    // random select runs and buttons, with an occasional long idle and one reset
    for (int r = 0; r < 60; r++) begin
      int n;
      sel_i = ~sel_i;
      n = $urandom_range(1, 25);
      if ($urandom_range(0, 9) == 0) n = T + $urandom_range(0, 3);
      repeat (n) begin
        btn_i = 12'($urandom);
        tick();
      end
      if (r == 30) begin
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
